// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared op/state encodings and helpers for the multiply/divide controller
package mdu_ctrl_pkg;

  localparam int MDU_OP_W = 3;
  localparam int DIV_STEPS = 32;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one radix-2 restoring division step
module mdu_div_step (
  input  logic [32:0] rem,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic        quo_bit
);

  logic [33:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    quo_bit  = (shifted >= {2'b00, divisor});
    diff     = shifted[32:0] - {1'b0, divisor};
    rem_next = quo_bit ? diff : shifted[32:0];
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - HI/LO multiply, multiply-accumulate and iterative divide controller
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         opa,
  input  logic [31:0]         opb,
  input  logic                cancel,
  input  logic [63:0]         hilo_rdata,
  output logic                stall,
  output logic                hilo_wen,
  output logic [63:0]         hilo_wdata
);

  mdu_state_e          state_q, state_d;
  logic                capture;
  logic [MDU_OP_W-1:0] op_q;
  logic [31:0]         opa_q, opb_q;
  logic [63:0]         hilo_q, result_q;
  logic [32:0]         rem_q, rem_nx;
  logic [31:0]         quo_q, quo_nx;
  logic [4:0]          cnt_q;
  logic                quo_bit;

  logic                signed_q, sign_a, sign_b;
  logic [31:0]         divisor;
  logic [63:0]         ext_a, ext_b, product, mul_result;
  logic [31:0]         quo_fix, rem_fix;
  logic [63:0]         div_result;

  always_comb begin
    signed_q = is_signed_op(op_q);
    sign_a   = signed_q & opa_q[31];
    sign_b   = signed_q & opb_q[31];
    divisor  = magnitude(opb_q, sign_b);

    ext_a   = signed_q ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q};
    ext_b   = signed_q ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q};
    product = ext_a * ext_b;

    case (op_q)
      OP_MADD, OP_MADDU: mul_result = hilo_q + product;
      OP_MSUB, OP_MSUBU: mul_result = hilo_q - product;
      default:           mul_result = product;
    endcase
  end

  mdu_div_step u_div_step (
    .rem          (rem_q),
    .dividend_bit (quo_q[31]),
    .divisor      (divisor),
    .rem_next     (rem_nx),
    .quo_bit      (quo_bit)
  );

  // The dividend shifts out of the top of quo_q while quotient bits shift in at the bottom.
  always_comb begin
    quo_nx  = {quo_q[30:0], quo_bit};
    quo_fix = (sign_a ^ sign_b) ? (~quo_nx + 32'd1) : quo_nx;
    rem_fix = sign_a ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];
    if (opb_q == 32'd0) begin
      div_result = {opa_q, 32'hFFFF_FFFF};
    end else begin
      div_result = {rem_fix, quo_fix};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    hilo_wen = 1'b0;
    capture  = 1'b0;
    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            stall   = 1'b1;
            capture = 1'b1;
            state_d = is_div_op(op) ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL: begin
          stall   = 1'b1;
          state_d = ST_DONE;
        end
        ST_DIV: begin
          stall = 1'b1;
          if (cnt_q == 5'(DIV_STEPS - 1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          hilo_wen = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      hilo_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else if (capture) begin
      op_q   <= op;
      opa_q  <= opa;
      opb_q  <= opb;
      hilo_q <= hilo_rdata;
      rem_q  <= '0;
      quo_q  <= magnitude(opa, is_signed_op(op) & opa[31]);
      cnt_q  <= '0;
    end else if (cancel) begin
      cnt_q <= '0;
    end else if (state_q == ST_MUL) begin
      result_q <= mul_result;
    end else if (state_q == ST_DIV) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (cnt_q == 5'(DIV_STEPS - 1)) begin
        result_q <= div_result;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  assign hilo_wdata = result_q;

endmodule
